// File: rtl/alu_seq.sv
// Accumulator sequencer: fetches 12-bit instructions, drives an external ALU
// and writes its result back into the accumulator and status flags.
module alu_seq #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] prog_addr,
   input  logic [11:0]       prog_data,
   output logic [3:0]        alu_inst,
   output logic [DATA_W-1:0] alu_b,
   output logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] alu_ans,
   input  logic              alu_carry,
   output logic              carry_flag,
   output logic              zero_flag,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      WB,
      HALT
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'd8;
   localparam logic [3:0] OP_CLR  = 4'd13;
   localparam logic [3:0] OP_SET  = 4'd14;
   localparam logic [3:0] OP_HALT = 4'd15;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [11:0]       ir_q, ir_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              c_q, c_d;
   logic              z_q, z_d;
   logic [3:0]        op;
   logic [DATA_W-1:0] mask;
   logic              alu_on;

   assign op     = ir_q[11:8];
   assign mask   = DATA_W'(1) << ir_q[2:0];
   assign alu_on = (state_q == EXEC) || (state_q == WB);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
         c_q     <= c_d;
         z_q     <= z_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      c_d     = c_q;
      z_d     = z_q;
      unique case (state_q)
         IDLE, HALT: begin
            if (start) begin
               pc_d    = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            ir_d    = prog_data;
            state_d = EXEC;
         end
         EXEC: state_d = WB;
         WB: begin
            if (op == OP_HALT) begin
               state_d = HALT;
            end else begin
               pc_d    = pc_q + 1'b1;
               state_d = FETCH;
               if (op == OP_CLR) begin
                  acc_d = acc_q & ~mask;
                  z_d   = (acc_d == '0);
               end else if (op == OP_SET) begin
                  acc_d = acc_q | mask;
                  z_d   = 1'b0;
               end else if (op != OP_NOP) begin
                  acc_d = alu_ans;
                  z_d   = (alu_ans == '0);
                  // only add/sub/inc/dec produce a meaningful carry
                  if (op == 4'd2 || op == 4'd3 ||
                      op == 4'd5 || op == 4'd6)
                     c_d = alu_carry;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign prog_addr  = pc_q;
   assign acc        = acc_q;
   assign carry_flag = c_q;
   assign zero_flag  = z_q;
   assign busy       = alu_on || (state_q == FETCH);
   assign done       = (state_q == HALT);
   assign alu_inst   = alu_on ? op : OP_NOP;
   assign alu_b      = alu_on ? DATA_W'(ir_q[7:0]) : '0;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: table of small programs with a scoreboard of final
// accumulator/flag state, plus hand sequences for reset, wrap and restart.
module tb_alu_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  prog_addr;
   logic [11:0] prog_data;
   logic [3:0]  alu_inst;
   logic [7:0]  alu_b;
   logic [7:0]  acc;
   logic [7:0]  alu_ans;
   logic        alu_carry;
   logic        carry_flag;
   logic        zero_flag;
   logic        busy;
   logic        done;

   logic [11:0] prog [256];
   int          n_chk;
   int          n_fail;

   alu_seq #(.DATA_W(8), .ADDR_W(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .alu_inst   (alu_inst),
      .alu_b      (alu_b),
      .acc        (acc),
      .alu_ans    (alu_ans),
      .alu_carry  (alu_carry),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign prog_data = prog[prog_addr];

   // Reference ALU; non-arithmetic ops drive carry=1 and unused ops drive
   // a junk result so that wrongly sampled outputs become visible.
   logic [8:0] s;
   always_comb begin
      s         = '0;
      alu_ans   = 8'h5C;
      alu_carry = 1'b1;
      case (alu_inst)
         4'd0:  alu_ans = alu_b;
         4'd1:  alu_ans = acc & alu_b;
         4'd2:  begin s = {1'b0, acc} + {1'b0, alu_b}; {alu_carry, alu_ans} = s; end
         4'd3:  begin s = {1'b0, acc} - {1'b0, alu_b}; {alu_carry, alu_ans} = s; end
         4'd4:  alu_ans = acc | alu_b;
         4'd5:  begin s = {1'b0, acc} + 9'd1; {alu_carry, alu_ans} = s; end
         4'd6:  begin s = {1'b0, acc} - 9'd1; {alu_carry, alu_ans} = s; end
         4'd7:  alu_ans = acc ^ alu_b;
         4'd9:  alu_ans = 8'h00;
         4'd10: alu_ans = ~acc;
         4'd11: alu_ans = acc << 1;
         4'd12: alu_ans = acc >> 1;
         default: ;
      endcase
   end

   typedef struct {
      logic [11:0] w [5];
      int          n;
      logic [7:0]  acc;
      logic        c;
      logic        z;
   } vec_t;

   typedef struct {
      logic [7:0] acc;
      logic       c;
      logic       z;
      int         cyc;
   } exp_t;

   vec_t vecs [$];
   exp_t sb [$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic add_vec(input logic [11:0] a, b, c, d, e, input int n,
                          input logic [7:0] ea, input logic ec, ez);
      vec_t v;
      v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d; v.w[4] = e;
      v.n = n; v.acc = ea; v.c = ec; v.z = ez;
      vecs.push_back(v);
   endtask

   task automatic load(input vec_t v);
      for (int i = 0; i < 256; i++) prog[i] = 12'hF00;
      for (int i = 0; i < 5; i++) prog[i] = v.w[i];
   endtask

   initial begin
      exp_t e;
      int   cyc;
      n_chk  = 0;
      n_fail = 0;
      start  = 1'b0;
      reset  = 1'b0;
      for (int i = 0; i < 256; i++) prog[i] = 12'hF00;

      add_vec(12'h005, 12'h203, 12'hF00, 12'hF00, 12'hF00, 3, 8'h08, 0, 0);
      add_vec(12'h0FF, 12'h500, 12'hF00, 12'hF00, 12'hF00, 3, 8'h00, 1, 1);
      add_vec(12'h0F0, 12'h220, 12'hF00, 12'hF00, 12'hF00, 3, 8'h10, 1, 0);
      add_vec(12'h003, 12'h305, 12'hF00, 12'hF00, 12'hF00, 3, 8'hFE, 1, 0);
      add_vec(12'h005, 12'h305, 12'hF00, 12'hF00, 12'hF00, 3, 8'h00, 0, 1);
      add_vec(12'h0F0, 12'h10F, 12'hF00, 12'hF00, 12'hF00, 3, 8'h00, 0, 1);
      add_vec(12'h000, 12'h600, 12'hF00, 12'hF00, 12'hF00, 3, 8'hFF, 1, 0);
      add_vec(12'h0AA, 12'h455, 12'h7FF, 12'hF00, 12'hF00, 4, 8'h00, 1, 1);
      add_vec(12'h001, 12'h201, 12'hB00, 12'hF00, 12'hF00, 4, 8'h04, 0, 0);
      add_vec(12'h0A5, 12'hA00, 12'hC00, 12'hF00, 12'hF00, 4, 8'h2D, 0, 0);
      add_vec(12'h0FF, 12'h800, 12'h800, 12'hF00, 12'hF00, 4, 8'hFF, 0, 0);
      add_vec(12'h900, 12'hE07, 12'hD07, 12'hF00, 12'hF00, 4, 8'h00, 0, 1);
      add_vec(12'h001, 12'hD00, 12'hF00, 12'hF00, 12'hF00, 3, 8'h00, 0, 1);
      add_vec(12'h000, 12'hE03, 12'hF00, 12'hF00, 12'hF00, 3, 8'h08, 0, 0);

      #3;
      chk("rst_acc", acc, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_inst", alu_inst, 4'h8);
      chk("rst_b", alu_b, 8'h00);
      chk("rst_pc", prog_addr, 8'h00);
      chk("rst_flags", {carry_flag, zero_flag}, 2'b00);
      @(negedge clk);
      reset = 1'b1;
      step(2);
      chk("idle_busy", busy, 1'b0);

      foreach (vecs[k]) begin
         load(vecs[k]);
         e.acc = vecs[k].acc;
         e.c   = vecs[k].c;
         e.z   = vecs[k].z;
         e.cyc = 3 * vecs[k].n;
         sb.push_back(e);
         pulse_start();
         chk($sformatf("v%0d_busy", k), busy, 1'b1);
         cyc = 0;
         while (!done && cyc < 100) begin
            step(1);
            cyc++;
         end
         e = sb.pop_front();
         chk($sformatf("v%0d_done", k), done, 1'b1);
         chk($sformatf("v%0d_cyc", k), cyc, e.cyc);
         chk($sformatf("v%0d_acc", k), acc, e.acc);
         chk($sformatf("v%0d_c", k), carry_flag, e.c);
         chk($sformatf("v%0d_z", k), zero_flag, e.z);
         chk($sformatf("v%0d_hbusy", k), busy, 1'b0);
      end

      // reset in EXEC aborts the instruction
      for (int i = 0; i < 256; i++) prog[i] = 12'hF00;
      prog[0] = 12'h0AA;
      pulse_start();
      step(1);
      chk("ex_inst", alu_inst, 4'h0);
      chk("ex_b", alu_b, 8'hAA);
      #2 reset = 1'b0;
      #1;
      chk("ar_acc", acc, 8'h00);
      chk("ar_busy", busy, 1'b0);
      chk("ar_inst", alu_inst, 4'h8);
      chk("ar_b", alu_b, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      step(5);
      chk("ar_acc2", acc, 8'h00);
      chk("ar_busy2", busy, 1'b0);
      chk("ar_done2", done, 1'b0);

      // set/clear bit with intermediate accumulator values
      prog[0] = 12'h900; prog[1] = 12'hE07;
      prog[2] = 12'hD07; prog[3] = 12'hF00;
      pulse_start();
      step(3);
      chk("bit_a0", acc, 8'h00);
      step(3);
      chk("bit_a1", acc, 8'h80);
      chk("bit_z1", zero_flag, 1'b0);
      step(3);
      chk("bit_a2", acc, 8'h00);
      chk("bit_z2", zero_flag, 1'b1);
      step(3);
      chk("bit_done", done, 1'b1);

      // preload acc=95, carry=1 then run nops across the pc wrap
      prog[0] = 12'h0A5; prog[1] = 12'h2F0; prog[2] = 12'hF00;
      pulse_start();
      step(9);
      chk("pre_acc", acc, 8'h95);
      for (int i = 0; i < 256; i++) prog[i] = 12'h800;
      pulse_start();
      chk("nop_pc0", prog_addr, 8'h00);
      step(3 * 255);
      chk("nop_pcff", prog_addr, 8'hFF);
      chk("nop_busyff", busy, 1'b1);
      step(3);
      chk("wrap_pc", prog_addr, 8'h00);
      chk("wrap_busy", busy, 1'b1);
      chk("wrap_acc", acc, 8'h95);
      chk("wrap_flags", {carry_flag, zero_flag}, 2'b10);
      step(3);
      chk("wrap_pc1", prog_addr, 8'h01);
      prog[3] = 12'hF00;
      step(2);
      pulse_start();
      chk("busy_start_pc", prog_addr, 8'h02);
      chk("busy_start_b", busy, 1'b1);
      step(6);
      chk("halt_done", done, 1'b1);
      chk("halt_pc", prog_addr, 8'h03);
      pulse_start();
      chk("restart_pc", prog_addr, 8'h00);
      chk("restart_busy", busy, 1'b1);
      chk("restart_done", done, 1'b0);
      chk("restart_acc", acc, 8'h95);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
